gate_cq: RTL
============

# gate_cq

Completion-path companion to the memory request gateway. It returns a completion for every DMA request, including requests the gateway refused, so the requester always gets one. It forwards completions from memory for authorized requests and synthesizes error completions for denied ones. It tracks outstanding authorized requests and drops completions that no outstanding request can explain. One instance serves one direction (rd or wr); the shell instantiates two.

## Interface
Parameters:
- PID_BITS, 6, width of requester process ID
- DEST_BITS, 4, width of destination/stream tag
- DENY_DEPTH, 8, depth of the deny FIFO (power of 2, ≥2)
- MAX_OUTST, 64, outstanding-request counter ceiling
- STARVE_LIMIT, 4, number of consecutive pass-through grants allowed while error completions wait

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- req_fire  in  1  an authorized request was accepted downstream (valid&ready on the filtered request channel)
- deny_valid  in  1  the gateway rejected a request
- deny_ready  out  1  = !fifo_full; forced 0 while aresetn is low
- deny_pid  in  PID_BITS  PID of the rejected request
- deny_dest  in  DEST_BITS  dest of the rejected request
- s_cq_valid / s_cq_ready  in / out  1  completion from memory
- s_cq_pid  in  PID_BITS  completion PID
- s_cq_dest  in  DEST_BITS  completion dest
- m_cq_valid  out  1  completion to the requester
- m_cq_ready  in  1  completion to the requester
- m_cq_pid  out  PID_BITS  registered
- m_cq_dest  out  DEST_BITS  registered
- m_cq_err  out  1  registered; 1 = access denied
- outstanding  out  $clog2(MAX_OUTST+1)  current outstanding count
- deny_count  out  32  denied requests enqueued
- spurious_count  out  32  unmatched completions dropped
- outst_ovf  out  1  sticky; set on req_fire at MAX_OUTST

## Operation
- **Outstanding counter**
  - Increments on req_fire.
  - Decrements on an accepted s_cq handshake when the count is >0.
  - Both in one cycle: unchanged.
  - req_fire at MAX_OUTST: the count holds and outst_ovf is set.
- **Spurious completion**
  - Condition: s_cq_valid with the pre-update count ==0.
  - s_cq_ready=1, the completion is not forwarded, spurious_count+1.
  - If req_fire occurs in the same cycle, the count becomes 1.
- **Deny path**
  - A deny handshake pushes {pid,dest} into the FIFO and increments deny_count.
  - deny_count and spurious_count wrap at 2^32.
- **Output stage**
  - Single register; loads when empty or when m_cq_ready=1.
  - Sources:
    - pass-through: s_cq with count>0, err=0
    - error: FIFO head, err=1
- **Arbiter FSM**, states PASS_PRI and ERR_FORCE:
  - PASS_PRI: pass-through wins if valid. starve_cnt+1 each pass grant while the FIFO is non-empty; reset to 0 otherwise.
  - starve_cnt==STARVE_LIMIT → ERR_FORCE.
  - ERR_FORCE: the next load takes the FIFO head, then returns to PASS_PRI with starve_cnt=0.
- **s_cq_ready** = (count==0) | (load & pass granted).
- **FIFO pop** only on an error grant into the output register.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): m_cq_valid/pid/dest/err=0, outstanding=0, counters=0, outst_ovf=0, FIFO empty, FSM=PASS_PRI, deny_ready=0 during reset and 1 on the first cycle after.
- Pass-through latency: 1 cycle (handshake at edge N → m_cq_valid from N+1).
- Error completion latency: ≥2 cycles after the deny handshake, due to the registered FIFO read.
- Throughput: 1 completion/cycle. m_cq fields are stable while valid&!ready.
- FIFO full: deny_ready=0; the upstream gateway holds the request. A push and a pop in the same cycle at full is not permitted (deny_ready is already 0); at empty, the pop precedes visibility.
- Reset mid-operation: all queued denies, the output register and the count are discarded immediately.

## Structure
- lynxTypes:
  - cq_entry_t {err, pid, dest}
  - GATE_CQ_STARVE_LIMIT default
- Sub-module gate_cq_fifo: synchronous FIFO, async active-low reset, registered head output, full/empty flags.
- Arbiter, counters and output register live in gate_cq.

## Test plan
- **Reset**: assert aresetn=0 mid-traffic → all outputs 0, deny_ready=0; after release deny_ready=1, outstanding=0.
- **Pass-through**: 3 req_fire, then 3 s_cq (pid 1–3) with m_cq_ready=1 → 3 m_cq, err=0, each 1 cycle after its handshake; outstanding 3→0.
- **Spurious completion**: s_cq pid=7 with outstanding=0 → s_cq_ready=1, no m_cq_valid, spurious_count=1.
- **Deny, idle memory**: deny pid=5 dest=2 → m_cq err=1 pid=5 dest=2 two cycles later; deny_count=1.
- **Starvation**: outstanding=10, continuous s_cq, one queued deny, STARVE_LIMIT=4 → 4 pass, then 1 err, then pass resumes.
- **Backpressure/full**: m_cq_ready=0, 9 denies → the first is held in the output register; deny_ready falls after the 9th handshake. Release m_cq_ready → 9 err completions in order, deny_ready returns to 1.

Source files
------------

// File: rtl/gate_cq_pkg.sv
// ============================================================================
// Module   : gate_cq_pkg
// Brief    : Shared types and defaults for the completion-path gateway.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gate_cq_pkg;

   localparam int GATE_CQ_PID_BITS     = 6;
   localparam int GATE_CQ_DEST_BITS    = 4;
   localparam int GATE_CQ_STARVE_LIMIT = 4;

   // Default-width view of one completion as seen by the shell.
   typedef struct packed {
      logic                         err;
      logic [GATE_CQ_PID_BITS-1:0]  pid;
      logic [GATE_CQ_DEST_BITS-1:0] dest;
   } cq_entry_t;

   typedef enum logic [0:0] {
      PASS_PRI  = 1'b0,
      ERR_FORCE = 1'b1
   } arb_state_t;

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/gate_cq_fifo.sv
// ============================================================================
// Module   : gate_cq_fifo
// Brief    : Synchronous FIFO with a registered head stage and full flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_cq_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             head_valid,
   output logic             full
);

   localparam int               c_AW   = $clog2(DEPTH);
   localparam logic [c_AW:0]    c_ONE  = (c_AW + 1)'(1);
   localparam logic [c_AW:0]    c_FULL = (c_AW + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW:0]    r_wr_ptr;
   logic [c_AW:0]    r_rd_ptr;
   logic [c_AW:0]    r_total;
   logic [WIDTH-1:0] r_head;
   logic             r_head_valid;

   logic w_push;
   logic w_pop;
   logic w_mem_nonempty;
   logic w_head_load;

   assign w_push         = push & (r_total != c_FULL);
   assign w_pop          = pop & r_head_valid;
   assign w_mem_nonempty = (r_wr_ptr != r_rd_ptr);
   // A word written this cycle only becomes visible at the head next cycle.
   assign w_head_load    = w_mem_nonempty & (~r_head_valid | w_pop);

   always_ff @(posedge aclk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_total      <= '0;
         r_head       <= '0;
         r_head_valid <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ONE;
         end
         if (w_head_load) begin
            r_head       <= r_mem[r_rd_ptr[c_AW-1:0]];
            r_rd_ptr     <= r_rd_ptr + c_ONE;
            r_head_valid <= 1'b1;
         end else if (w_pop) begin
            r_head_valid <= 1'b0;
         end
         if (w_push && !w_pop) begin
            r_total <= r_total + c_ONE;
         end else if (!w_push && w_pop) begin
            r_total <= r_total - c_ONE;
         end
      end
   end

   assign head_data  = r_head;
   assign head_valid = r_head_valid;
   assign full       = (r_total == c_FULL);

endmodule

`default_nettype wire

// File: rtl/gate_cq.sv
// ============================================================================
// Module   : gate_cq
// Brief    : Completion path: forwards memory completions, synthesizes error
//            completions for denied requests, drops unexplained completions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_cq
   import gate_cq_pkg::*;
#(
   parameter int PID_BITS     = GATE_CQ_PID_BITS,
   parameter int DEST_BITS    = GATE_CQ_DEST_BITS,
   parameter int DENY_DEPTH   = 8,
   parameter int MAX_OUTST    = 64,
   parameter int STARVE_LIMIT = GATE_CQ_STARVE_LIMIT
) (
   input  logic                             aclk,
   input  logic                             aresetn,
   input  logic                             req_fire,
   input  logic                             deny_valid,
   output logic                             deny_ready,
   input  logic [PID_BITS-1:0]              deny_pid,
   input  logic [DEST_BITS-1:0]             deny_dest,
   input  logic                             s_cq_valid,
   output logic                             s_cq_ready,
   input  logic [PID_BITS-1:0]              s_cq_pid,
   input  logic [DEST_BITS-1:0]             s_cq_dest,
   output logic                             m_cq_valid,
   input  logic                             m_cq_ready,
   output logic [PID_BITS-1:0]              m_cq_pid,
   output logic [DEST_BITS-1:0]             m_cq_dest,
   output logic                             m_cq_err,
   output logic [$clog2(MAX_OUTST+1)-1:0]   outstanding,
   output logic [31:0]                      deny_count,
   output logic [31:0]                      spurious_count,
   output logic                             outst_ovf
);

   localparam int             c_CW   = cnt_width(MAX_OUTST);
   localparam int             c_SW   = cnt_width(STARVE_LIMIT);
   localparam int             c_EW   = PID_BITS + DEST_BITS;
   localparam logic [c_CW-1:0] c_MAX  = c_CW'(MAX_OUTST);
   localparam logic [c_CW-1:0] c_CONE = c_CW'(1);
   localparam logic [c_SW-1:0] c_SLIM = c_SW'(STARVE_LIMIT);
   localparam logic [c_SW-1:0] c_SONE = c_SW'(1);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic [c_SW-1:0]   r_starve;
   logic [c_SW-1:0]   w_starve_nxt;
   logic [c_CW-1:0]   r_outst;
   logic [31:0]       r_deny_cnt;
   logic [31:0]       r_spur_cnt;
   logic              r_ovf;
   logic              r_m_valid;
   logic              r_m_err;
   logic [PID_BITS-1:0]  r_m_pid;
   logic [DEST_BITS-1:0] r_m_dest;

   logic              w_cnt_zero;
   logic              w_pass_vld;
   logic              w_err_vld;
   logic              w_load;
   logic              w_grant_pass;
   logic              w_grant_err;
   logic              w_push;
   logic              w_full;
   logic [c_EW-1:0]   w_head;

   gate_cq_fifo #(
      .WIDTH (c_EW),
      .DEPTH (DENY_DEPTH)
   ) u_deny_fifo (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .push       (w_push),
      .push_data  ({deny_pid, deny_dest}),
      .pop        (w_grant_err),
      .head_data  (w_head),
      .head_valid (w_err_vld),
      .full       (w_full)
   );

   assign deny_ready = aresetn & ~w_full;
   assign w_push     = deny_valid & deny_ready;
   assign w_cnt_zero = (r_outst == '0);
   assign w_pass_vld = s_cq_valid & ~w_cnt_zero;
   assign w_load     = ~r_m_valid | m_cq_ready;
   // With nothing outstanding every completion is accepted and dropped.
   assign s_cq_ready = w_cnt_zero | w_grant_pass;

   always_comb begin
      w_grant_pass = 1'b0;
      w_grant_err  = 1'b0;
      w_state_nxt  = r_state;
      w_starve_nxt = r_starve;
      case (r_state)
         PASS_PRI: begin
            if (w_load) begin
               if (w_pass_vld) begin
                  w_grant_pass = 1'b1;
               end else if (w_err_vld) begin
                  w_grant_err = 1'b1;
               end
            end
            if (!w_err_vld || w_grant_err) begin
               w_starve_nxt = '0;
            end else if (w_grant_pass) begin
               w_starve_nxt = r_starve + c_SONE;
            end
            if (w_starve_nxt == c_SLIM) begin
               w_state_nxt = ERR_FORCE;
            end
         end
         ERR_FORCE: begin
            if (w_load && w_err_vld) begin
               w_grant_err  = 1'b1;
               w_state_nxt  = PASS_PRI;
               w_starve_nxt = '0;
            end
         end
         default: begin
            w_state_nxt  = PASS_PRI;
            w_starve_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state  <= PASS_PRI;
         r_starve <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_starve <= w_starve_nxt;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_m_valid <= 1'b0;
         r_m_err   <= 1'b0;
         r_m_pid   <= '0;
         r_m_dest  <= '0;
      end else if (w_load) begin
         r_m_valid <= w_grant_pass | w_grant_err;
         if (w_grant_pass) begin
            r_m_err  <= 1'b0;
            r_m_pid  <= s_cq_pid;
            r_m_dest <= s_cq_dest;
         end else if (w_grant_err) begin
            r_m_err  <= 1'b1;
            r_m_pid  <= w_head[c_EW-1:DEST_BITS];
            r_m_dest <= w_head[DEST_BITS-1:0];
         end
      end
   end

   // A pass grant is the only way a completion retires an outstanding request.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_outst    <= '0;
         r_ovf      <= 1'b0;
         r_deny_cnt <= '0;
         r_spur_cnt <= '0;
      end else begin
         if (req_fire && !w_grant_pass && (r_outst != c_MAX)) begin
            r_outst <= r_outst + c_CONE;
         end else if (!req_fire && w_grant_pass) begin
            r_outst <= r_outst - c_CONE;
         end
         if (req_fire && (r_outst == c_MAX)) begin
            r_ovf <= 1'b1;
         end
         if (w_push) begin
            r_deny_cnt <= r_deny_cnt + 32'd1;
         end
         if (s_cq_valid && w_cnt_zero) begin
            r_spur_cnt <= r_spur_cnt + 32'd1;
         end
      end
   end

   assign m_cq_valid     = r_m_valid;
   assign m_cq_err       = r_m_err;
   assign m_cq_pid       = r_m_pid;
   assign m_cq_dest      = r_m_dest;
   assign outstanding    = r_outst;
   assign deny_count     = r_deny_cnt;
   assign spurious_count = r_spur_cnt;
   assign outst_ovf      = r_ovf;

endmodule

`default_nettype wire
